// File: rtl/dds_sweep.sv
// dds_sweep: frequency-sweep controller placed in front of the DDS core.
// It steps a 24-bit tuning word from a start value to a stop value. Each
// value is held for Dwell+1 cycles. Three sweep modes are supported:
// single-shot, repeating (sawtooth) and continuous up/down (triangle).
//
// Ports
//   Clk        system clock, rising edge
//   nReset     synchronous, active-low reset
//   Start      starts a sweep; only sampled while idle
//   Abort      stops any sweep on the next edge; also wins over Start
//   Mode       00/11 single, 01 repeat, 10 up/down
//   StartFreq  first tuning word
//   StopFreq   last tuning word
//   Step       unsigned increment; 0 behaves as 1
//   Dwell      each tuning word is held for Dwell+1 cycles
//   Frequency  registered tuning word driven to the DDS
//   Sync       one-cycle pulse at every sweep (re)start; clears DDS phase
//   Busy       high while a sweep is active
//   Done       one-cycle pulse when a single sweep completes
module dds_sweep #(
  parameter int DWELL_W = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic               Abort,
  input  logic [1:0]         Mode,
  input  logic [23:0]        StartFreq,
  input  logic [23:0]        StopFreq,
  input  logic [23:0]        Step,
  input  logic [DWELL_W-1:0] Dwell,
  output logic [23:0]        Frequency,
  output logic               Sync,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic {
    IDLE,
    DWELL
  } state_t;

  // The sweep configuration is frozen when a sweep is accepted.
  typedef struct packed {
    logic [1:0]         mode;
    logic [23:0]        startFreq;
    logic [23:0]        stopFreq;
    logic [23:0]        step;
    logic [DWELL_W-1:0] dwell;
  } cfg_t;

  state_t             state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic               dirDown_q, dirDown_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [23:0]        freq_q, freq_d;
  logic               sync_q, sync_d;
  logic               done_q, done_d;

  logic               modeRepeat, modeUpDown, degenerate;
  logic [24:0]        upSum;
  logic signed [24:0] dnDiff;
  logic [23:0]        upNext, dnNext;

  // Candidate next words. Arithmetic is done one bit wider so that an up
  // step past 0xFFFFFF, or a down step below zero, clamps rather than wraps.
  always_comb begin
    modeRepeat = (cfg_q.mode == 2'b01);
    modeUpDown = (cfg_q.mode == 2'b10);
    degenerate = (cfg_q.startFreq >= cfg_q.stopFreq);
    upSum      = {1'b0, freq_q} + {1'b0, cfg_q.step};
    dnDiff     = $signed({1'b0, freq_q}) - $signed({1'b0, cfg_q.step});
    upNext     = (upSum >= {1'b0, cfg_q.stopFreq}) ? cfg_q.stopFreq : upSum[23:0];
    dnNext     = (dnDiff <= $signed({1'b0, cfg_q.startFreq})) ? cfg_q.startFreq
                                                                : dnDiff[23:0];
  end

  // Next-state logic. The "advance" decision is taken in the last dwell
  // cycle (counter at zero), so it does not cost an extra cycle.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    dirDown_d = dirDown_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    sync_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          cfg_d.mode      = Mode;
          cfg_d.startFreq = StartFreq;
          cfg_d.stopFreq  = StopFreq;
          cfg_d.step      = (Step == 24'd0) ? 24'd1 : Step;
          cfg_d.dwell     = Dwell;
          freq_d          = StartFreq;
          sync_d          = 1'b1;
          dirDown_d       = 1'b0;
          cnt_d           = Dwell;
          state_d         = DWELL;
        end
      end

      DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          cnt_d = cfg_q.dwell;
          if (!dirDown_q) begin
            // ">=" rather than "==" also covers a degenerate sweep whose
            // start word already lies above the stop word.
            if (freq_q >= cfg_q.stopFreq) begin
              if (modeRepeat) begin
                freq_d = cfg_q.startFreq;
                sync_d = 1'b1;
              end else if (modeUpDown) begin
                // A degenerate triangle has nowhere to go; hold the word.
                if (!degenerate) begin
                  dirDown_d = 1'b1;
                  freq_d    = dnNext;
                end
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              freq_d = upNext;
            end
          end else begin
            if (freq_q <= cfg_q.startFreq) begin
              dirDown_d = 1'b0;
              freq_d    = upNext;
            end else begin
              freq_d = dnNext;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a Start in the same cycle.
    if (Abort) begin
      state_d = IDLE;
      cfg_d   = cfg_q;
      freq_d  = freq_q;
      sync_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      dirDown_q <= 1'b0;
      cnt_q     <= '0;
      freq_q    <= '0;
      sync_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      dirDown_q <= dirDown_d;
      cnt_q     <= cnt_d;
      freq_q    <= freq_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
    end
  end

  assign Frequency = freq_q;
  assign Sync      = sync_q;
  assign Done      = done_q;
  assign Busy      = (state_q == DWELL);

endmodule

// File: tb/tb_dds_sweep.sv
// Testbench for dds_sweep. It runs directed scenarios and then randomized
// sweeps. Every cycle is compared against a reference model. When a sweep
// is accepted, the model builds the whole list of tuning words. It then
// walks that list, holding each word for Dwell+1 cycles.
module tb_dds_sweep;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          nReset;
  logic          Start;
  logic          Abort;
  logic [1:0]    Mode;
  logic [23:0]   StartFreq;
  logic [23:0]   StopFreq;
  logic [23:0]   Step;
  logic [DW-1:0] Dwell;
  logic [23:0]   Frequency;
  logic          Sync;
  logic          Busy;
  logic          Done;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  bit          mBusy;
  bit          mSync;
  bit          mDone;
  int unsigned mFreq;
  int          mIdx;
  int          mPhase;
  int          mDwell;
  logic [1:0]  mMode;
  int unsigned seqQ[$];

  dds_sweep #(.DWELL_W(DW)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Abort(Abort), .Mode(Mode),
    .StartFreq(StartFreq), .StopFreq(StopFreq), .Step(Step), .Dwell(Dwell),
    .Frequency(Frequency), .Sync(Sync), .Busy(Busy), .Done(Done)
  );

  // Free-running 10-time-unit clock
  always #5 Clk = ~Clk;

  // Single comparison point: count it, report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One sweep period as a list of tuning words. The up leg runs from start
  // to stop, clamped at stop. For up/down, the down leg adds the words
  // strictly between stop and start.
  task automatic buildSequence(input longint s, input longint e, input longint st,
                               input logic [1:0] md);
    longint v;
    longint inc;
    inc = (st == 0) ? 1 : st;
    seqQ.delete();
    seqQ.push_back(int'(s));
    if (s < e) begin
      v = s;
      while (v < e) begin
        v = v + inc;
        if (v > e) v = e;
        seqQ.push_back(int'(v));
      end
      if (md == 2'b10) begin
        v = e;
        forever begin
          v = v - inc;
          if (v <= s) break;
          seqQ.push_back(int'(v));
        end
      end
    end
  endtask

  // Model reaction to one rising edge, using the currently driven inputs
  task automatic modelEdge();
    if (!nReset) begin
      mBusy = 0; mSync = 0; mDone = 0; mFreq = 0;
    end else if (mBusy) begin
      mSync = 0; mDone = 0;
      if (Abort) begin
        mBusy = 0;
      end else begin
        mPhase++;
        if (mPhase == mDwell + 1) begin
          mPhase = 0;
          mIdx++;
          if (mIdx == seqQ.size()) begin
            if (mMode == 2'b01 || mMode == 2'b10) begin
              mIdx  = 0;
              mFreq = seqQ[0];
              mSync = (mMode == 2'b01);
            end else begin
              mBusy = 0;
              mDone = 1;
            end
          end else begin
            mFreq = seqQ[mIdx];
          end
        end
      end
    end else begin
      mSync = 0; mDone = 0;
      if (Start && !Abort) begin
        mMode  = Mode;
        mDwell = int'(Dwell);
        buildSequence(longint'(StartFreq), longint'(StopFreq), longint'(Step), Mode);
        mBusy  = 1;
        mSync  = 1;
        mFreq  = seqQ[0];
        mIdx   = 0;
        mPhase = 0;
      end
    end
  endtask

  // Drive one cycle of control inputs, clock it, and compare all outputs
  task automatic applyStimulus(input bit rstN, input bit st, input bit ab);
    nReset = rstN;
    Start  = st;
    Abort  = ab;
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput("Frequency", 32'(Frequency), mFreq);
    checkOutput("Sync", 32'(Sync), 32'(mSync));
    checkOutput("Busy", 32'(Busy), 32'(mBusy));
    checkOutput("Done", 32'(Done), 32'(mDone));
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic startSweep(input logic [23:0] s, input logic [23:0] e,
                            input logic [23:0] st, input logic [DW-1:0] d,
                            input logic [1:0] md);
    StartFreq = s;
    StopFreq  = e;
    Step      = st;
    Dwell     = d;
    Mode      = md;
    applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  // Random configuration covering tiny, zero, large and degenerate steps
  task automatic randomizeConfig();
    int     sel;
    longint s, e, st, inc;
    sel = $urandom_range(0, 5);
    if (sel == 0)      st = $urandom_range(0, 3);
    else if (sel == 1) st = longint'($urandom & 32'h00FF_FFFF);
    else               st = $urandom_range(1, 5000);
    inc = (st == 0) ? 1 : st;
    s = longint'($urandom & 32'h00FF_FFFF);
    if (sel == 5) begin
      e = s - longint'($urandom_range(0, int'(s)));
    end else begin
      e = s + inc * longint'($urandom_range(0, 10)) + longint'($urandom_range(0, int'(inc) - 1));
      if (e > 64'h00FF_FFFF) e = 64'h00FF_FFFF;
    end
    StartFreq = s[23:0];
    StopFreq  = e[23:0];
    Step      = st[23:0];
    Dwell     = DW'($urandom_range(0, 4));
    Mode      = 2'($urandom_range(0, 3));
  endtask

  initial begin
    nReset = 1'b0; Start = 1'b0; Abort = 1'b0; Mode = 2'b00;
    StartFreq = '0; StopFreq = '0; Step = '0; Dwell = '0;
    mBusy = 0; mSync = 0; mDone = 0; mFreq = 0;
    mIdx = 0; mPhase = 0; mDwell = 0; mMode = 2'b00;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resetFreq", 32'(Frequency), 32'd0);
    checkOutput("resetBusy", 32'(Busy), 32'd0);

    // Single sweep 100..130 step 10, dwell 2
    startSweep(24'd100, 24'd130, 24'd10, DW'(2), 2'b00);
    checkOutput("t1FirstFreq", 32'(Frequency), 32'd100);
    checkOutput("t1FirstSync", 32'(Sync), 32'd1);
    runCycles(12);
    checkOutput("t1DoneAt13", 32'(Done), 32'd1);
    checkOutput("t1LastFreq", 32'(Frequency), 32'd130);
    runCycles(3);
    checkOutput("t1IdleBusy", 32'(Busy), 32'd0);
    checkOutput("t1HoldFreq", 32'(Frequency), 32'd130);

    // Clamp at stop, then no wrap at the top of the 24-bit range
    startSweep(24'd100, 24'd125, 24'd10, DW'(0), 2'b00);
    runCycles(3);
    checkOutput("t2Clamp", 32'(Frequency), 32'd125);
    runCycles(1);
    checkOutput("t2Done", 32'(Done), 32'd1);
    startSweep(24'hFFFF00, 24'hFFFFFF, 24'h80, DW'(0), 2'b00);
    runCycles(2);
    checkOutput("t2TopClamp", 32'(Frequency), 32'hFFFFFF);
    runCycles(2);
    checkOutput("t2NoWrap", 32'(Frequency), 32'hFFFFFF);

    // Up/down triangle 0..20 step 8
    startSweep(24'd0, 24'd20, 24'd8, DW'(0), 2'b10);
    runCycles(4);
    checkOutput("t3Turn", 32'(Frequency), 32'd12);
    runCycles(16);
    checkOutput("t3StillBusy", 32'(Busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Repeat sawtooth 5..7 step 1, dwell 1
    startSweep(24'd5, 24'd7, 24'd1, DW'(1), 2'b01);
    runCycles(6);
    checkOutput("t4RestartSync", 32'(Sync), 32'd1);
    checkOutput("t4RestartFreq", 32'(Frequency), 32'd5);
    runCycles(8);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Start while busy is ignored; abort holds the word; abort beats start
    startSweep(24'd100, 24'd130, 24'd10, DW'(2), 2'b00);
    runCycles(2);
    StartFreq = 24'd7;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t5AbortBusy", 32'(Busy), 32'd0);
    checkOutput("t5AbortHold", 32'(Frequency), 32'd110);
    runCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5AbortWins", 32'(Busy), 32'd0);

    // Reset mid-sweep, then a degenerate single sweep
    startSweep(24'd100, 24'd130, 24'd10, DW'(2), 2'b00);
    runCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t6ResetFreq", 32'(Frequency), 32'd0);
    startSweep(24'd50, 24'd40, 24'd10, DW'(3), 2'b00);
    runCycles(3);
    checkOutput("t6DegHold", 32'(Frequency), 32'd50);
    runCycles(1);
    checkOutput("t6DegDone", 32'(Done), 32'd1);

    // Randomized sweeps with stray Start/Abort/reset and config churn
    for (int sweep = 0; sweep < 40; sweep++) begin
      randomizeConfig();
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int c = 0; c < int'($urandom_range(10, 120)); c++) begin
        if ($urandom_range(0, 9) == 0) randomizeConfig();
        applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 59) == 0);
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
